// File: rtl/stream_deserializer.sv
// Collects N_SAMPLES stream words into one wide frame, first word in the least-significant slot,
// then presents the frame downstream and holds it until it is accepted.
module stream_deserializer #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [BIT_WIDTH-1:0]             recv_msg,
    input  logic                             recv_val,
    output logic                             recv_rdy,
    output logic [N_SAMPLES*BIT_WIDTH-1:0]   send_msg,
    output logic                             send_val,
    input  logic                             send_rdy,
    output logic [$clog2(N_SAMPLES+1)-1:0]   fill_count
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_SAMPLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_e;

    state_e               state_q;
    logic [CNT_W-1:0]     fill_q;
    logic [BIT_WIDTH-1:0] buf_q [N_SAMPLES];
    logic                 recv_rdy_q;
    logic                 send_val_q;

    // Handshake outputs are registered alongside the state so neither depends on recv_val/send_rdy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= COLLECT;
            fill_q     <= '0;
            recv_rdy_q <= 1'b1;
            send_val_q <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                COLLECT: begin
                    if (recv_val) begin
                        // Slot select compares against the counter, so a full count never writes.
                        for (int i = 0; i < N_SAMPLES; i++) begin
                            if (fill_q == CNT_W'(i)) begin
                                buf_q[i] <= recv_msg;
                            end
                        end
                        fill_q <= fill_q + CNT_W'(1);
                        if (fill_q == LAST_SLOT) begin
                            state_q    <= SEND;
                            recv_rdy_q <= 1'b0;
                            send_val_q <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    // Buffer is left intact after the hand-off; the next frame overwrites it.
                    if (send_rdy) begin
                        state_q    <= COLLECT;
                        fill_q     <= '0;
                        recv_rdy_q <= 1'b1;
                        send_val_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < N_SAMPLES; g++) begin : g_pack
        assign send_msg[g*BIT_WIDTH +: BIT_WIDTH] = buf_q[g];
    end

    assign recv_rdy   = recv_rdy_q;
    assign send_val   = send_val_q;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_stream_deserializer.sv
// Bench for stream_deserializer with N_SAMPLES=4, BIT_WIDTH=32: directed scenarios plus a
// randomized run against a queue-based frame model.
module tb_stream_deserializer;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [W-1:0]     recv_msg;
    logic             recv_val;
    logic             recv_rdy;
    logic [N*W-1:0]   send_msg;
    logic             send_val;
    logic             send_rdy;
    logic [CW-1:0]    fill_count;

    int errors = 0;
    int checks = 0;

    stream_deserializer #(.BIT_WIDTH(W), .N_SAMPLES(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .recv_msg   (recv_msg),
        .recv_val   (recv_val),
        .recv_rdy   (recv_rdy),
        .send_msg   (send_msg),
        .send_val   (send_val),
        .send_rdy   (send_rdy),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic test_reset();
        reset = 1'b1; recv_val = 1'b1; recv_msg = 32'hFFFF_FFFF; send_rdy = 1'b1;
        step();
        step();
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL reset_send_val got=%b exp=0", send_val); end
        checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL reset_recv_rdy got=%b exp=1", recv_rdy); end
        checks++; if (fill_count !== CW'(0)) begin errors++; $display("FAIL reset_fill got=%0d exp=0", fill_count); end
        checks++; if (send_msg !== '0) begin errors++; $display("FAIL reset_send_msg got=%h exp=0", send_msg); end
        reset = 1'b0; recv_val = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        send_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            recv_val = 1'b1; recv_msg = words[i];
            step();
            checks++;
            if (fill_count !== CW'(i + 1)) begin errors++; $display("FAIL b2b_fill[%0d] got=%0d exp=%0d", i, fill_count, i + 1); end
        end
        recv_val = 1'b0;
        checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL b2b_send_val got=%b exp=1", send_val); end
        checks++; if (recv_rdy !== 1'b0) begin errors++; $display("FAIL b2b_recv_rdy got=%b exp=0", recv_rdy); end
        checks++;
        if (send_msg !== pack4(32'h11, 32'h22, 32'h33, 32'h44)) begin
            errors++; $display("FAIL b2b_frame got=%h exp=%h", send_msg, pack4(32'h11, 32'h22, 32'h33, 32'h44));
        end
        step();
        checks++; if (fill_count !== CW'(0)) begin errors++; $display("FAIL b2b_after_fill got=%0d exp=0", fill_count); end
        checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL b2b_after_rdy got=%b exp=1", recv_rdy); end
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL b2b_after_val got=%b exp=0", send_val); end
    endtask

    task automatic test_gapped();
        logic [W-1:0] words [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        int taken = 0;
        send_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            recv_val = (i % 2 == 0);
            recv_msg = recv_val ? words[i/2] : $urandom;
            if (recv_val) taken++;
            step();
            checks++;
            if (fill_count !== CW'(taken)) begin errors++; $display("FAIL gap_fill[%0d] got=%0d exp=%0d", i, fill_count, taken); end
        end
        recv_val = 1'b0;
        checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL gap_send_val got=%b exp=1", send_val); end
        checks++;
        if (send_msg !== pack4(32'h11, 32'h22, 32'h33, 32'h44)) begin
            errors++; $display("FAIL gap_frame got=%h exp=%h", send_msg, pack4(32'h11, 32'h22, 32'h33, 32'h44));
        end
        step();
        checks++; if (fill_count !== CW'(0)) begin errors++; $display("FAIL gap_after_fill got=%0d exp=0", fill_count); end
    endtask

    task automatic test_stall();
        logic [W-1:0] words [4];
        logic [N*W-1:0] exp;
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        exp = pack4(words[0], words[1], words[2], words[3]);
        send_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            recv_val = 1'b1; recv_msg = words[i];
            step();
        end
        for (int c = 0; c < 10; c++) begin
            recv_val = 1'($urandom_range(0, 1)); recv_msg = $urandom;
            step();
            checks++;
            if (send_val !== 1'b1 || recv_rdy !== 1'b0 || send_msg !== exp || fill_count !== CW'(N)) begin
                errors++;
                $display("FAIL stall[%0d] got val=%b rdy=%b fill=%0d msg=%h exp val=1 rdy=0 fill=%0d msg=%h",
                         c, send_val, recv_rdy, fill_count, send_msg, N, exp);
            end
        end
        recv_val = 1'b0; send_rdy = 1'b1;
        step();
        checks++; if (send_val !== 1'b0 || fill_count !== CW'(0)) begin errors++; $display("FAIL stall_release got val=%b fill=%0d exp val=0 fill=0", send_val, fill_count); end
        step();
        checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL stall_single_xfer got=%b exp=0", send_val); end
    endtask

    task automatic test_reset_mid_frame();
        logic [N*W-1:0] exp;
        send_rdy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            recv_val = 1'b1; recv_msg = 32'hDEAD_0000 + i;
            step();
        end
        reset = 1'b1; recv_val = 1'b1; recv_msg = 32'hBAD0_BAD0;
        step();
        reset = 1'b0;
        checks++; if (fill_count !== CW'(0)) begin errors++; $display("FAIL rstmid_fill got=%0d exp=0", fill_count); end
        checks++; if (send_msg !== '0) begin errors++; $display("FAIL rstmid_clear got=%h exp=0", send_msg); end
        for (int i = 0; i < 4; i++) begin
            recv_val = 1'b1; recv_msg = 32'hA + i;
            step();
        end
        recv_val = 1'b0;
        exp = pack4(32'hA, 32'hB, 32'hC, 32'hD);
        checks++; if (send_val !== 1'b1 || send_msg !== exp) begin errors++; $display("FAIL rstmid_frame got val=%b msg=%h exp val=1 msg=%h", send_val, send_msg, exp); end
        step();
    endtask

    task automatic test_two_frames();
        logic [W-1:0] words [8];
        int wi = 0;
        int nframes = 0;
        int tstamp [2];
        logic [N*W-1:0] got [2];
        for (int i = 0; i < 8; i++) words[i] = 32'h100 + i;
        send_rdy = 1'b1;
        for (int c = 0; c < 14; c++) begin
            recv_val = 1'b1;
            recv_msg = (wi < 8) ? words[wi] : 32'hFACE_FACE;
            if (recv_rdy && wi < 8) wi++;
            step();
            if (send_val && nframes < 2) begin
                tstamp[nframes] = c; got[nframes] = send_msg; nframes++;
            end
        end
        recv_val = 1'b0;
        checks++; if (nframes != 2) begin errors++; $display("FAIL two_count got=%0d exp=2", nframes); end
        if (nframes == 2) begin
            checks++; if (tstamp[1] - tstamp[0] != 5) begin errors++; $display("FAIL two_spacing got=%0d exp=5", tstamp[1] - tstamp[0]); end
            checks++; if (got[0] !== pack4(words[0], words[1], words[2], words[3])) begin errors++; $display("FAIL two_frame0 got=%h exp=%h", got[0], pack4(words[0], words[1], words[2], words[3])); end
            checks++; if (got[1] !== pack4(words[4], words[5], words[6], words[7])) begin errors++; $display("FAIL two_frame1 got=%h exp=%h", got[1], pack4(words[4], words[5], words[6], words[7])); end
        end
        send_rdy = 1'b1;
        step();
        step();
    endtask

    // Model: a queue of words accepted so far plus a pending frame awaiting hand-off.
    task automatic test_random();
        logic [W-1:0]   q [$];
        logic           pend = 1'b0;
        logic [N*W-1:0] mframe = '0;
        int             frames = 0;
        int             exp_fill;
        reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0;
        step();
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            exp_fill = pend ? N : q.size();
            checks++;
            if (recv_rdy !== !pend || send_val !== pend || fill_count !== CW'(exp_fill)) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] got rdy=%b val=%b fill=%0d exp rdy=%b val=%b fill=%0d",
                         c, recv_rdy, send_val, fill_count, !pend, pend, exp_fill);
            end
            if (pend) begin
                checks++;
                if (send_msg !== mframe) begin errors++; $display("FAIL rand_frame[%0d] got=%h exp=%h", c, send_msg, mframe); end
            end
            recv_val = 1'($urandom_range(0, 1));
            send_rdy = ($urandom_range(0, 3) != 0);
            recv_msg = $urandom;
            if (pend) begin
                if (send_rdy) begin pend = 1'b0; frames++; end
            end else if (recv_val) begin
                q.push_back(recv_msg);
                if (q.size() == N) begin
                    for (int i = 0; i < N; i++) mframe[i*W +: W] = q[i];
                    q.delete();
                    pend = 1'b1;
                end
            end
            step();
        end
        checks++; if (frames < 10) begin errors++; $display("FAIL rand_progress got=%0d exp>=10", frames); end
    endtask

    initial begin
        reset = 1'b0; recv_val = 1'b0; recv_msg = '0; send_rdy = 1'b0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_stall();
        test_reset_mid_frame();
        test_two_frames();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
